// File: rtl/lw_sha_schedule.sv
// SHA-256 message-schedule stage: loads a 16-word block into a circular W file,
// then streams W0..W63 over valid/ready, expanding and writing back in place for t >= 16.

module lw_sha_expansion (
  input  logic [15:0][31:0] i_w,
  input  logic [3:0]        i_round_index,
  output logic [31:0]       o_expanded_word
);

  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // Slot t[3:0] still holds W(t-16); the other taps sit at fixed offsets mod 16.
  logic [3:0] w_idx_m15;
  logic [3:0] w_idx_m7;
  logic [3:0] w_idx_m2;

  assign w_idx_m15 = i_round_index + 4'd1;
  assign w_idx_m7  = i_round_index + 4'd9;
  assign w_idx_m2  = i_round_index + 4'd14;

  assign o_expanded_word = f_sig1(i_w[w_idx_m2]) + i_w[w_idx_m7] +
                           f_sig0(i_w[w_idx_m15]) + i_w[i_round_index];

endmodule

module lw_sha_schedule #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WORD_W-1:0] i_in_data,
  output logic              o_wt_valid,
  input  logic              i_wt_ready,
  output logic [WORD_W-1:0] o_wt_data,
  output logic [5:0]        o_wt_round,
  output logic              o_wt_last,
  output logic              o_busy
);

  typedef enum logic {StLoad = 1'b0, StRun = 1'b1} state_e;

  state_e                   r_state;
  state_e                   w_state_d;
  logic [15:0][WORD_W-1:0]  r_w;
  logic [3:0]               r_ld_cnt;
  logic [5:0]               r_t;

  logic                     w_in_hs;
  logic                     w_wt_hs;
  logic                     w_last;
  logic [WORD_W-1:0]        w_expanded;

  lw_sha_expansion u_expansion (
    .i_w             (r_w),
    .i_round_index   (r_t[3:0]),
    .o_expanded_word (w_expanded)
  );

  assign o_in_ready = (r_state == StLoad);
  assign o_wt_valid = (r_state == StRun);
  assign o_busy     = (r_state == StRun);
  assign o_wt_round = r_t;
  assign w_last     = (r_t == 6'(ROUNDS - 1));
  assign o_wt_last  = o_wt_valid && w_last;
  assign o_wt_data  = (r_t < 6'd16) ? r_w[r_t[3:0]] : w_expanded;

  assign w_in_hs = i_in_valid && o_in_ready;
  assign w_wt_hs = o_wt_valid && i_wt_ready;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StLoad:  if (w_in_hs && (r_ld_cnt == 4'd15)) w_state_d = StRun;
      StRun:   if (w_wt_hs && w_last) w_state_d = StLoad;
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StLoad;
      r_ld_cnt <= '0;
      r_t      <= '0;
      r_w      <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_in_hs) begin
        r_w[r_ld_cnt] <= i_in_data;
        r_ld_cnt      <= r_ld_cnt + 4'd1;
      end
      if (w_wt_hs) begin
        // Write-back overwrites W(t-16), which no later round needs.
        if (r_t >= 6'd16) r_w[r_t[3:0]] <= w_expanded;
        r_t <= w_last ? 6'd0 : r_t + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_lw_sha_schedule.sv
// Bench for lw_sha_schedule: directed and randomized blocks against a FIPS 180-4 schedule model.

module tb_lw_sha_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        wt_valid;
  logic        wt_ready;
  logic [31:0] wt_data;
  logic [5:0]  wt_round;
  logic        wt_last;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] blk[16];
  logic [31:0] exp_w[64];
  logic [31:0] obs_w[64];

  lw_sha_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .o_wt_valid (wt_valid),
    .i_wt_ready (wt_ready),
    .o_wt_data  (wt_data),
    .o_wt_round (wt_round),
    .o_wt_last  (wt_last),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // FIPS 180-4 message schedule over the whole 64-entry array.
  task automatic build_model();
    logic [31:0] s0;
    logic [31:0] s1;
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load_block(input bit gaps, input int n, output int first_edge);
    int  acc   = 0;
    int  guard = 0;
    bit  seen  = 0;
    first_edge = -1;
    while (acc < n && guard < 400) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = blk[acc];
      end
      if (in_valid && !seen) begin
        first_edge = cyc;
        seen = 1;
      end
      check("load_state", 32'({in_ready, wt_valid, busy}), 32'b100);
      @(posedge clk); #1;
      if (in_valid) acc++;
      guard++;
    end
    in_valid = 1'b0;
    check("load_budget", 32'(acc), 32'(n));
    if (n == 16) begin
      check("emit_latency", 32'({wt_valid, in_ready}), 32'b10);
      check("emit_round0", 32'(wt_round), 32'd0);
    end
  endtask

  task automatic run_block(input bit bp, input bit poke, input int stop_at,
                           output int hs, output int last_edge);
    int          idx   = 0;
    int          guard = 0;
    bit          held  = 0;
    logic [31:0] pd    = '0;
    logic [5:0]  pr    = '0;
    hs = 0;
    last_edge = -1;
    while (idx < 64 && idx != stop_at && guard < 2000) begin
      wt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      check("run_state", 32'({wt_valid, in_ready, busy}), 32'b101);
      if (held) begin
        check("hold_data", wt_data, pd);
        check("hold_round", 32'(wt_round), 32'(pr));
      end
      if (wt_ready) begin
        check($sformatf("wt_data[%0d]", idx), wt_data, exp_w[idx]);
        check("wt_round", 32'(wt_round), 32'(idx));
        check("wt_last", 32'(wt_last), 32'(idx == 63));
        obs_w[idx] = wt_data;
        if (idx == 63) last_edge = cyc;
      end
      pd   = wt_data;
      pr   = wt_round;
      held = !wt_ready;
      @(posedge clk); #1;
      if (wt_ready) begin
        idx++;
        hs++;
      end
      guard++;
    end
    wt_ready = 1'b0;
    in_valid = 1'b0;
    if (stop_at < 0) begin
      check("run_budget", 32'(idx), 32'd64);
      check("turnaround", 32'({in_ready, wt_valid, wt_last}), 32'b100);
    end
  endtask

  initial begin
    int e0;
    int e1;
    int hs;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    wt_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(wt_valid), 32'd0);
    check("rst_data", wt_data, 32'd0);
    check("rst_round", 32'(wt_round), 32'd0);
    check("rst_last_busy", 32'({wt_last, busy}), 32'd0);

    // "abc" at full rate
    set_abc();
    build_model();
    load_block(1'b0, 16, e0);
    run_block(1'b0, 1'b0, -1, hs, e1);
    check("abc_w0", obs_w[0], 32'h61626380);
    check("abc_w15", obs_w[15], 32'h00000018);
    check("abc_w16", obs_w[16], 32'h61626380);
    check("abc_w17", obs_w[17], 32'h000F0000);
    check("abc_w18", obs_w[18], 32'h7DA86405);

    // "abc" under random backpressure
    load_block(1'b0, 16, e0);
    run_block(1'b1, 1'b0, -1, hs, e1);
    check("bp_handshakes", 32'(hs), 32'd64);

    // Input gaps during load, in_valid poked during run
    set_random();
    build_model();
    load_block(1'b1, 16, e0);
    run_block(1'b0, 1'b1, -1, hs, e1);

    // Reset mid-run at t=30
    set_abc();
    build_model();
    load_block(1'b0, 16, e0);
    run_block(1'b0, 1'b0, 30, hs, e1);
    check("pre_reset_round", 32'(wt_round), 32'd30);
    pulse_reset();
    check("mr_state", 32'({wt_valid, in_ready}), 32'b01);
    check("mr_round", 32'(wt_round), 32'd0);
    load_block(1'b0, 16, e0);
    run_block(1'b0, 1'b0, -1, hs, e1);

    // Reset mid-load after 7 words, then a fresh random block
    set_random();
    load_block(1'b0, 7, e0);
    pulse_reset();
    set_random();
    build_model();
    load_block(1'b0, 16, e0);
    run_block(1'b0, 1'b0, -1, hs, e1);

    // Back-to-back random blocks at full rate
    set_random();
    build_model();
    load_block(1'b0, 16, e0);
    run_block(1'b0, 1'b0, -1, hs, e1);
    set_random();
    build_model();
    load_block(1'b0, 16, hs);
    run_block(1'b0, 1'b0, -1, hs, e1);
    check("b2b_cycles", 32'(e1 - e0 + 1), 32'd160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
